decoder_scan_seq: RTL and testbench

//   Parametrised, registered N-to-2^N one-hot decoder with two modes.
//   - DIRECT: latches a select code on Load and holds the one-hot output.
//   - SCAN: steps the active output through all 2^N positions, dwelling

---
 rtl/decoder_scan_seq.sv | 107 ++++++++++
 tb/tb_decoder_scan_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq.sv
// ============================================================================
// Module      : decoder_scan_seq
// Description : Registered N-to-2^N one-hot decoder with DIRECT (hold) and
//               SCAN (step every DWELL cycles) modes for digit/row strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan_seq #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        i,
  output logic [(1<<N)-1:0]   d,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int C_CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [C_CNT_W-1:0] c_cnt_last = C_CNT_W'(DWELL - 1);
  localparam logic [C_CNT_W-1:0] c_cnt_one  = C_CNT_W'(1);
  localparam logic [N-1:0]       c_idx_last = {N{1'b1}};
  localparam logic [N-1:0]       c_idx_one  = N'(1);
  localparam logic [(1<<N)-1:0]  c_hot_base = (1<<N)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [N-1:0]         r_idx,   w_idx_nxt;
  logic [C_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic                 r_wrap,  w_wrap_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Load outranks mode: a load always lands its code, mode only picks the state.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = '0;
    w_wrap_nxt  = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mode) begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = load ? i : '0;
          end else if (load) begin
            w_state_nxt = ST_DIRECT;
            w_idx_nxt   = i;
          end
        end
        ST_DIRECT: begin
          if (load) w_idx_nxt = i;
          if (mode) w_state_nxt = ST_SCAN;
        end
        ST_SCAN: begin
          if (load) begin
            w_idx_nxt   = i;
            w_state_nxt = mode ? ST_SCAN : ST_DIRECT;
          end else if (!mode) begin
            w_state_nxt = ST_DIRECT;
          end else if (r_cnt != c_cnt_last) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end else begin
            w_idx_nxt  = r_idx + c_idx_one;
            w_wrap_nxt = (r_idx == c_idx_last);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come from flops only, so async reset blanks them immediately.
  assign d    = (r_state == ST_IDLE) ? '0 : (c_hot_base << r_idx);
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: N=2/DWELL=3 instance plus an
// N=3/DWELL=1 instance, checked through an expectation queue.
`default_nettype none

module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
  logic [1:0] i_a = '0;
  logic [3:0] d_a;
  logic [1:0] idx_a;
  logic       wrap_a;
  logic       en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
  logic [2:0] i_b = '0;
  logic [7:0] d_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;
    bit         is_b;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_scan_seq #(.N(2), .DWELL(3)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .load(load_a),
    .i(i_a), .d(d_a), .idx(idx_a), .wrap(wrap_a)
  );

  decoder_scan_seq #(.N(3), .DWELL(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .load(load_b),
    .i(i_b), .d(d_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic check_pop();
    exp_t        e;
    logic [11:0] obs, req;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed nothing queued, expected an entry");
      return;
    end
    e   = sb.pop_front();
    obs = e.is_b ? {d_b, idx_b, wrap_b} : {4'b0000, d_a, 1'b0, idx_a, wrap_a};
    req = {e.d, e.idx, e.wrap};
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed d=%b idx=%0d wrap=%b, expected d=%b idx=%0d wrap=%b",
             e.tag, obs[11:4], obs[3:1], obs[0], req[11:4], req[3:1], req[0]);
    end
  endtask

  task automatic push_a(input string tag, input int exp_d, input int exp_idx, input bit exp_w);
    exp_t e;
    e.tag = tag; e.d = 8'(exp_d); e.idx = 3'(exp_idx); e.wrap = exp_w; e.is_b = 1'b0;
    sb.push_back(e);
  endtask

  task automatic step_a(input string tag, input logic e, input logic m, input logic l,
                        input int s, input int exp_d, input int exp_idx, input bit exp_w);
    @(negedge clk);
    en_a = e; mode_a = m; load_a = l; i_a = 2'(s);
    push_a(tag, exp_d, exp_idx, exp_w);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic step_b(input string tag, input int exp_d, input int exp_idx, input bit exp_w);
    exp_t e;
    @(negedge clk);
    en_b = 1'b1; mode_b = 1'b1; load_b = 1'b0; i_b = '0;
    en_a = 1'b0;
    e.tag = tag; e.d = 8'(exp_d); e.idx = 3'(exp_idx); e.wrap = exp_w; e.is_b = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
    total++;
    assert ($onehot(d_b)) else begin
      bad++;
      $error("FAIL onehot_b: observed d=%b, expected exactly one bit set", d_b);
    end
  endtask

  initial begin
    // Reset state while rst is held.
    #12;
    push_a("reset", 0, 0, 1'b0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;

    // DIRECT loads, one cycle latency each.
    for (int s = 0; s < 4; s++) step_a("direct_load", 1, 0, 1, s, 1 << s, s, 1'b0);
    step_a("direct_hold", 1, 0, 0, 0, 4'b1000, 3, 1'b0);
    step_a("idle_en0", 0, 0, 0, 0, 0, 3, 1'b0);

    // SCAN from IDLE: 3 cycles per position, wrap pulse after 12.
    for (int k = 0; k < 15; k++)
      step_a("scan_period", 1, 1, 0, 0, 1 << ((k / 3) % 4), (k / 3) % 4, k == 12);
    step_a("idle_again", 0, 1, 0, 0, 0, 0, 1'b0);

    // Jump with Load at idx0/cnt1; new position dwells a full 3 cycles.
    step_a("scan_c0", 1, 1, 0, 0, 4'b0001, 0, 1'b0);
    step_a("scan_c1", 1, 1, 0, 0, 4'b0001, 0, 1'b0);
    step_a("scan_jump", 1, 1, 1, 2, 4'b0100, 2, 1'b0);
    step_a("jump_dwell1", 1, 1, 0, 0, 4'b0100, 2, 1'b0);
    step_a("jump_dwell2", 1, 1, 0, 0, 4'b0100, 2, 1'b0);
    step_a("jump_next", 1, 1, 0, 0, 4'b1000, 3, 1'b0);

    // Drop to DIRECT at idx3, blank with en=0, restart scan from 0.
    step_a("freeze", 1, 0, 0, 0, 4'b1000, 3, 1'b0);
    step_a("freeze_hold", 1, 0, 0, 0, 4'b1000, 3, 1'b0);
    step_a("blank", 0, 1, 0, 0, 0, 3, 1'b0);
    step_a("restart", 1, 1, 0, 0, 4'b0001, 0, 1'b0);

    // Load back to 0 from idx3 is a jump, not a wrap.
    for (int k = 1; k < 10; k++)
      step_a("scan_to3", 1, 1, 0, 0, 1 << (k / 3), k / 3, 1'b0);
    step_a("load_to0_nowrap", 1, 1, 1, 0, 4'b0001, 0, 1'b0);
    for (int k = 1; k < 13; k++)
      step_a("scan_to_wrap", 1, 1, 0, 0, 1 << ((k / 3) % 4), (k / 3) % 4, k == 12);

    // Asynchronous reset while wrap is high, between edges.
    #2;
    rst = 1'b1;
    #1;
    push_a("async_reset", 0, 0, 1'b0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    en_a = 1'b0;

    // DWELL=1, N=3: advance every cycle, wrap every 8th.
    for (int k = 0; k < 18; k++)
      step_b("scan_fast", 1 << (k % 8), k % 8, (k > 0) && (k % 8 == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
